// File: rtl/pc_sequencer.sv
// Program-counter controller: hold, step, relative branch, call and return with a
// one-cycle fetch bubble after taken transfers. Return stack enabled by CALL_STACK_EN.
module pc_sequencer #(
  parameter int           DEPTH    = 4,
  parameter logic [7:0]   RESET_PC = 8'h00
) (
  input  logic       Clk,
  input  logic       Clear_n,
  input  logic       Stall,
  input  logic       Halt,
  input  logic       Branch,
  input  logic       Call,
  input  logic       Ret,
  input  logic [7:0] Offset,
  output logic [7:0] PC,
  output logic       Fetch_Valid,
  output logic       Flush,
  output logic       Halted,
  output logic       Stack_Err
);

  localparam logic [1:0] ST_BOOT  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;
  localparam logic [1:0] ST_HALT  = 2'b11;

  logic [1:0] state_r;
  logic [1:0] state_n_s;
  logic [7:0] pc_r;
  logic [7:0] pc_n_s;
  logic [7:0] pc_inc_s;
  logic [7:0] target_s;
  logic       fetch_valid_r;
  logic       flush_r;
  logic       halted_r;
  logic       push_s;
  logic       pop_s;
  logic       err_set_s;
  logic       stk_empty_s;
  logic       stk_full_s;
  logic [7:0] stk_top_s;

  assign pc_inc_s = pc_r + 8'd1;
  assign target_s = pc_inc_s + Offset;

`ifdef CALL_STACK_EN
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [7:0]     stack_r [DEPTH];
  logic [SPW-1:0] sp_r;
  logic [AW-1:0]  top_idx_s;
  logic           err_r;

  assign top_idx_s   = sp_r[AW-1:0] - AW'(1);
  assign stk_top_s   = stack_r[top_idx_s];
  assign stk_empty_s = (sp_r == {SPW{1'b0}});
  assign stk_full_s  = (sp_r == SP_FULL);
  assign Stack_Err   = err_r;

  // Stack pointer and sticky error flag
  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      sp_r  <= {SPW{1'b0}};
      err_r <= 1'b0;
    end else begin
      if (push_s) begin
        sp_r <= sp_r + SP_ONE;
      end else if (pop_s) begin
        sp_r <= sp_r - SP_ONE;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Return-address storage; emptiness is tracked by sp_r so contents need no reset
  always_ff @(posedge Clk) begin
    if (push_s) begin
      stack_r[sp_r[AW-1:0]] <= pc_inc_s;
    end
  end
`else
  logic unused_s;

  // Without storage a Ret always sees an empty stack and falls to a sequential step
  assign stk_empty_s = 1'b1;
  assign stk_full_s  = 1'b0;
  assign stk_top_s   = 8'h00;
  assign Stack_Err   = 1'b0;
  assign unused_s    = ^{push_s, pop_s, err_set_s, stk_full_s, stk_top_s, 5'(DEPTH)};
`endif

  // Next-state and next-PC decode with RUN request priority
  always_comb begin
    state_n_s = state_r;
    pc_n_s    = pc_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_n_s = ST_RUN;
      end
      ST_RUN: begin
        if (Stall) begin
          state_n_s = ST_RUN;
        end else if (Halt) begin
          state_n_s = ST_HALT;
        end else if (Ret && !stk_empty_s) begin
          pc_n_s    = stk_top_s;
          pop_s     = 1'b1;
          state_n_s = ST_FLUSH;
        end else if (Ret) begin
          pc_n_s    = pc_inc_s;
          err_set_s = 1'b1;
        end else if (Call) begin
          pc_n_s    = target_s;
          state_n_s = ST_FLUSH;
          if (stk_full_s) begin
            err_set_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end else if (Branch) begin
          pc_n_s    = target_s;
          state_n_s = ST_FLUSH;
        end else begin
          pc_n_s = pc_inc_s;
        end
      end
      ST_FLUSH: begin
        state_n_s = ST_RUN;
      end
      ST_HALT: begin
        state_n_s = ST_HALT;
      end
      default: begin
        state_n_s = ST_BOOT;
        pc_n_s    = RESET_PC;
      end
    endcase
  end

  // State, PC and status outputs, all registered from the next state
  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      fetch_valid_r <= 1'b0;
      flush_r       <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      pc_r          <= pc_n_s;
      fetch_valid_r <= (state_n_s == ST_RUN);
      flush_r       <= (state_n_s == ST_FLUSH);
      halted_r      <= (state_n_s == ST_HALT);
    end
  end

  assign PC          = pc_r;
  assign Fetch_Valid = fetch_valid_r;
  assign Flush       = flush_r;
  assign Halted      = halted_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; expectations follow CALL_STACK_EN.
module tb_pc_sequencer;

  logic       Clk = 1'b0;
  logic       Clear_n = 1'b0;
  logic       Stall = 1'b0, Halt = 1'b0, Branch = 1'b0, Call = 1'b0, Ret = 1'b0;
  logic [7:0] Offset = 8'h00;
  logic [7:0] PC;
  logic       Fetch_Valid, Flush, Halted, Stack_Err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       stall, halt, branch, call, ret;
    logic [7:0] off;
    logic [7:0] pc;
    logic       fv, fl, hl, er;
  } vec_t;

  vec_t vecs[$];

  pc_sequencer #(.DEPTH(4), .RESET_PC(8'h00)) dut (
    .Clk(Clk), .Clear_n(Clear_n), .Stall(Stall), .Halt(Halt), .Branch(Branch),
    .Call(Call), .Ret(Ret), .Offset(Offset), .PC(PC), .Fetch_Valid(Fetch_Valid),
    .Flush(Flush), .Halted(Halted), .Stack_Err(Stack_Err)
  );

  always #5 Clk = ~Clk;

  task automatic add(input logic s, h, b, c, r, input logic [7:0] off,
                     input logic [7:0] pc, input logic fv, fl, hl, er);
    vec_t v;
    v.stall = s; v.halt = h; v.branch = b; v.call = c; v.ret = r; v.off = off;
    v.pc = pc; v.fv = fv; v.fl = fl; v.hl = hl; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] pc, input logic fv, fl, hl, er);
    n_vec++;
    if ({PC, Fetch_Valid, Flush, Halted, Stack_Err} !== {pc, fv, fl, hl, er}) begin
      n_bad++;
      $display("FAIL %s: got PC=%h FV=%b FL=%b HL=%b ER=%b, want PC=%h FV=%b FL=%b HL=%b ER=%b",
               nm, PC, Fetch_Valid, Flush, Halted, Stack_Err, pc, fv, fl, hl, er);
    end
  endtask

  initial begin
    // common part, starting from PC=02 in RUN
    add(0,0,1,0,0,8'h0D, 8'h10,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'h10,1,0,0,0);
    add(0,0,1,0,0,8'hF0, 8'h01,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'h01,1,0,0,0);
    add(0,0,0,0,0,8'h00, 8'h02,1,0,0,0);
    add(0,0,1,0,0,8'hFC, 8'hFF,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'hFF,1,0,0,0);
    add(0,0,0,0,0,8'h00, 8'h00,1,0,0,0);
    add(0,0,1,0,0,8'hFD, 8'hFE,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'hFE,1,0,0,0);
    add(0,0,1,0,0,8'h05, 8'h04,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'h04,1,0,0,0);
    add(1,0,1,0,0,8'h33, 8'h04,1,0,0,0);
    add(1,1,0,0,0,8'h33, 8'h04,1,0,0,0);
    add(1,0,0,1,1,8'h33, 8'h04,1,0,0,0);
    add(0,0,0,0,0,8'h00, 8'h05,1,0,0,0);
    add(0,0,1,0,0,8'h0A, 8'h10,0,1,0,0);
    add(1,1,1,1,1,8'h33, 8'h10,1,0,0,0);
    add(0,0,0,0,0,8'h00, 8'h11,1,0,0,0);
    add(0,0,1,0,0,8'h0E, 8'h20,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'h20,1,0,0,0);
    add(0,0,0,1,0,8'h10, 8'h31,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'h31,1,0,0,0);
    add(0,0,0,0,0,8'h00, 8'h32,1,0,0,0);
    add(0,0,0,0,0,8'h00, 8'h33,1,0,0,0);
`ifdef CALL_STACK_EN
    add(0,0,0,0,1,8'h00, 8'h21,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'h21,1,0,0,0);
    add(0,0,0,1,0,8'h10, 8'h32,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'h32,1,0,0,0);
    add(0,0,0,1,0,8'h10, 8'h43,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'h43,1,0,0,0);
    add(0,0,0,1,0,8'h10, 8'h54,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'h54,1,0,0,0);
    add(0,0,0,1,0,8'h10, 8'h65,0,1,0,0);
    add(0,0,0,0,0,8'h00, 8'h65,1,0,0,0);
    add(0,0,0,1,0,8'h10, 8'h76,0,1,0,1);
    add(0,0,0,0,0,8'h00, 8'h76,1,0,0,1);
    add(0,0,1,1,1,8'h10, 8'h55,0,1,0,1);
    add(0,0,0,0,0,8'h00, 8'h55,1,0,0,1);
    add(0,0,0,0,1,8'h00, 8'h44,0,1,0,1);
    add(0,0,0,0,0,8'h00, 8'h44,1,0,0,1);
    add(0,0,0,0,1,8'h00, 8'h33,0,1,0,1);
    add(0,0,0,0,0,8'h00, 8'h33,1,0,0,1);
    add(0,0,0,0,1,8'h00, 8'h22,0,1,0,1);
    add(0,0,0,0,0,8'h00, 8'h22,1,0,0,1);
    add(0,0,0,0,1,8'h00, 8'h23,1,0,0,1);
    add(0,0,0,0,1,8'h00, 8'h24,1,0,0,1);
    add(0,1,1,0,0,8'h05, 8'h24,0,0,1,1);
    add(0,0,1,1,1,8'h05, 8'h24,0,0,1,1);
    add(0,0,0,0,0,8'h00, 8'h24,0,0,1,1);
`else
    add(0,0,0,0,1,8'h00, 8'h34,1,0,0,0);
    add(0,0,0,0,0,8'h00, 8'h35,1,0,0,0);
    add(0,1,1,0,0,8'h05, 8'h35,0,0,1,0);
    add(0,0,1,1,1,8'h05, 8'h35,0,0,1,0);
    add(0,0,0,0,0,8'h00, 8'h35,0,0,1,0);
`endif

    // reset and boot sequence
    step(); step();
    chk("reset_hold", 8'h00, 0, 0, 0, 0);
    Clear_n = 1'b1;
    #1 chk("boot_cycle", 8'h00, 0, 0, 0, 0);
    step(); chk("run_first", 8'h00, 1, 0, 0, 0);
    step(); chk("run_seq1", 8'h01, 1, 0, 0, 0);
    step(); chk("run_seq2", 8'h02, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      Stall = vecs[i].stall; Halt = vecs[i].halt; Branch = vecs[i].branch;
      Call = vecs[i].call; Ret = vecs[i].ret; Offset = vecs[i].off;
      step();
      chk($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fv, vecs[i].fl, vecs[i].hl, vecs[i].er);
    end
    {Stall, Halt, Branch, Call, Ret} = 5'b00000;
    Offset = 8'h00;

    // asynchronous reset out of HALT, then mid-FLUSH
    #1 Clear_n = 1'b0;
    #1 chk("reset_in_halt", 8'h00, 0, 0, 0, 0);
    step();
    Clear_n = 1'b1;
    step(); chk("reboot_run", 8'h00, 1, 0, 0, 0);
    step(); chk("reboot_seq", 8'h01, 1, 0, 0, 0);
    Branch = 1'b1; Offset = 8'h20;
    step(); chk("flush_entry", 8'h22, 0, 1, 0, 0);
    Branch = 1'b0;
    #2 Clear_n = 1'b0;
    #1 chk("reset_in_flush", 8'h00, 0, 0, 0, 0);
    step();
    Clear_n = 1'b1;
    step(); chk("post_reset_run", 8'h00, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
